// File: rtl/arb_pkg.sv
// Shared types and constants for the round-robin / fixed-priority arbiter.
package arb_pkg;

  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} arb_state_t;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;
  localparam int BUSY_W     = 16;

endpackage

// File: rtl/prio_pick.sv
// Combinational priority picker: finds the first set request bit scanning
// from a start index, either ascending (wrapping N-1 -> 0) or descending (wrapping 0 -> N-1).
module prio_pick #(
  parameter  int N      = 4,
  parameter  int ASCEND = 1,
  localparam int IDX_W  = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] start,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  // The first hit in scan order wins; later hits are masked by found.
  always_comb begin
    int               j;
    logic [IDX_W-1:0] jj;
    found = 1'b0;
    idx   = '0;
    j     = 0;
    jj    = '0;
    for (int i = 0; i < N; i++) begin
      if (ASCEND != 0) begin
        j = int'(start) + i;
        if (j >= N) j = j - N;
      end else begin
        j = int'(start) - i;
        if (j < 0) j = j + N;
      end
      jj = IDX_W'(j);
      if (!found && req[jj]) begin
        found = 1'b1;
        idx   = jj;
      end
    end
  end

endmodule

// File: rtl/rr_priority_arbiter.sv
// N-requester arbiter with registered one-hot grant, grant/hold/release
// handshake, fixed or round-robin priority, and a saturating busy counter.
module rr_priority_arbiter
  import arb_pkg::*;
#(
  parameter  int N       = 4,
  parameter  int RR_MODE = MODE_FIXED,
  localparam int IDX_W   = $clog2(N)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [N-1:0]      req,
  input  logic              done,
  output logic [N-1:0]      grant,
  output logic [IDX_W-1:0]  grant_idx,
  output logic              grant_valid,
  output logic [BUSY_W-1:0] busy_cycles
);

  arb_state_t       state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] start;
  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;
  logic             release_now;

  // Round-robin scans upward from the pointer; fixed mode scans down from the top bit.
  assign start = (RR_MODE == MODE_RR) ? ptr : IDX_W'(N - 1);

  prio_pick #(
    .N      (N),
    .ASCEND ((RR_MODE == MODE_RR) ? 1 : 0)
  ) u_pick (
    .req   (req),
    .start (start),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign release_now = done || !req[grant_idx] || !en;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      grant       <= '0;
      grant_idx   <= '0;
      grant_valid <= 1'b0;
      ptr         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (en && pick_found) begin
            grant           <= '0;
            grant[pick_idx] <= 1'b1;
            grant_idx       <= pick_idx;
            grant_valid     <= 1'b1;
            state           <= GRANT;
            if (RR_MODE == MODE_RR)
              ptr <= (pick_idx == IDX_W'(N - 1)) ? '0 : pick_idx + 1'b1;
          end
        end
        // No preemption: the grant only ends on the holder's release conditions.
        GRANT: begin
          if (release_now) begin
            grant       <= '0;
            grant_idx   <= '0;
            grant_valid <= 1'b0;
            state       <= RELEASE;
          end
        end
        RELEASE: begin
          state <= IDLE;
        end
        default: begin
          state       <= IDLE;
          grant       <= '0;
          grant_idx   <= '0;
          grant_valid <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      busy_cycles <= '0;
    else if (grant_valid && (busy_cycles != '1))
      busy_cycles <= busy_cycles + 1'b1;
  end

endmodule

// File: tb/tb_rr_priority_arbiter.sv
// Directed bench: table-driven fixed-priority vectors, then hand-written
// round-robin, reset and counter/width sequences.
module tb_rr_priority_arbiter;
  import arb_pkg::*;

  typedef struct {
    logic        rst;
    logic        en;
    logic [3:0]  req;
    logic        done;
    logic [3:0]  g;
    logic [1:0]  ix;
    logic        v;
    logic [15:0] b;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset, en, done;
  logic [3:0]  req;
  logic [7:0]  req8;

  logic [3:0]  fix_grant;
  logic [1:0]  fix_idx;
  logic        fix_valid;
  logic [15:0] fix_busy;
  logic [3:0]  rr_grant;
  logic [1:0]  rr_idx;
  logic        rr_valid;
  logic [15:0] rr_busy;
  logic [7:0]  w8_grant;
  logic [2:0]  w8_idx;
  logic        w8_valid;
  logic [15:0] w8_busy;

  int checks = 0;
  int errors = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  rr_priority_arbiter #(.N(4), .RR_MODE(MODE_FIXED)) dut_fix (
    .clk(clk), .reset(reset), .en(en), .req(req), .done(done),
    .grant(fix_grant), .grant_idx(fix_idx), .grant_valid(fix_valid), .busy_cycles(fix_busy)
  );

  rr_priority_arbiter #(.N(4), .RR_MODE(MODE_RR)) dut_rr (
    .clk(clk), .reset(reset), .en(en), .req(req), .done(done),
    .grant(rr_grant), .grant_idx(rr_idx), .grant_valid(rr_valid), .busy_cycles(rr_busy)
  );

  rr_priority_arbiter #(.N(8), .RR_MODE(MODE_RR)) dut_w8 (
    .clk(clk), .reset(reset), .en(en), .req(req8), .done(done),
    .grant(w8_grant), .grant_idx(w8_idx), .grant_valid(w8_valid), .busy_cycles(w8_busy)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic e, input logic [3:0] q, input logic d);
    reset = r;
    en    = e;
    req   = q;
    done  = d;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkInv(input string name, input logic [31:0] g, input int idx, input logic v);
    logic [31:0] bit_at_idx;
    bit_at_idx = (g >> idx) & 32'd1;
    checkOutput({name, " onehot0"}, {31'd0, $onehot0(g)}, 32'd1);
    checkOutput({name, " valid==|grant"}, {31'd0, v}, {31'd0, |g});
    if (v) checkOutput({name, " grant[idx]"}, bit_at_idx, 32'd1);
  endtask

  // Structural invariants on every DUT, sampled away from the active edge.
  always @(negedge clk) begin
    checkInv("inv fix", {28'd0, fix_grant}, int'(fix_idx), fix_valid);
    checkInv("inv rr",  {28'd0, rr_grant},  int'(rr_idx),  rr_valid);
    checkInv("inv w8",  {24'd0, w8_grant},  int'(w8_idx),  w8_valid);
  end

  function automatic vec_t mkv(input logic r, input logic e, input logic [3:0] q, input logic d,
                               input logic [3:0] g, input logic [1:0] ix, input logic v,
                               input logic [15:0] b);
    vec_t t;
    t.rst = r; t.en = e; t.req = q; t.done = d;
    t.g = g; t.ix = ix; t.v = v; t.b = b;
    return t;
  endfunction

  initial begin
    reset = 1'b1;
    en    = 1'b0;
    req   = 4'b0000;
    done  = 1'b0;
    req8  = 8'h00;

    // Fixed-priority table: inputs applied before an edge, outputs expected after it.
    vecs.push_back(mkv(1, 0, 4'b0000, 0, 4'b0000, 0, 0, 0));
    vecs.push_back(mkv(1, 0, 4'b0000, 0, 4'b0000, 0, 0, 0));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mkv(0, 1, 4'b0000, 0, 4'b0000, 0, 0, 0));
    vecs.push_back(mkv(0, 1, 4'b0110, 0, 4'b0100, 2, 1, 0));
    vecs.push_back(mkv(0, 1, 4'b1110, 0, 4'b0100, 2, 1, 1));
    vecs.push_back(mkv(0, 1, 4'b1110, 0, 4'b0100, 2, 1, 2));
    vecs.push_back(mkv(0, 1, 4'b1110, 1, 4'b0000, 0, 0, 3));
    vecs.push_back(mkv(0, 1, 4'b1110, 0, 4'b0000, 0, 0, 3));
    vecs.push_back(mkv(0, 1, 4'b1110, 0, 4'b1000, 3, 1, 3));
    vecs.push_back(mkv(0, 1, 4'b1110, 0, 4'b1000, 3, 1, 4));
    vecs.push_back(mkv(0, 1, 4'b0110, 0, 4'b0000, 0, 0, 5));
    vecs.push_back(mkv(0, 1, 4'b0110, 0, 4'b0000, 0, 0, 5));
    vecs.push_back(mkv(0, 1, 4'b0110, 0, 4'b0100, 2, 1, 5));
    vecs.push_back(mkv(0, 0, 4'b0110, 0, 4'b0000, 0, 0, 6));
    vecs.push_back(mkv(0, 0, 4'b1111, 0, 4'b0000, 0, 0, 6));
    vecs.push_back(mkv(0, 0, 4'b1111, 0, 4'b0000, 0, 0, 6));
    vecs.push_back(mkv(0, 0, 4'b1111, 0, 4'b0000, 0, 0, 6));
    vecs.push_back(mkv(0, 1, 4'b1111, 1, 4'b1000, 3, 1, 6));
    vecs.push_back(mkv(0, 1, 4'b1111, 0, 4'b1000, 3, 1, 7));
    vecs.push_back(mkv(1, 1, 4'b1111, 0, 4'b0000, 0, 0, 0));
    vecs.push_back(mkv(0, 1, 4'b1111, 0, 4'b1000, 3, 1, 0));
    vecs.push_back(mkv(0, 1, 4'b1111, 1, 4'b0000, 0, 0, 1));
    vecs.push_back(mkv(0, 1, 4'b1111, 1, 4'b0000, 0, 0, 1));
    vecs.push_back(mkv(0, 1, 4'b0001, 0, 4'b0001, 0, 1, 1));

    $display("[TB] fixed-priority table: %0d vectors", vecs.size());
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].en, vecs[i].req, vecs[i].done);
      checkOutput($sformatf("vec%0d grant", i), {28'd0, fix_grant}, {28'd0, vecs[i].g});
      checkOutput($sformatf("vec%0d idx", i),   {30'd0, fix_idx},   {30'd0, vecs[i].ix});
      checkOutput($sformatf("vec%0d valid", i), {31'd0, fix_valid}, {31'd0, vecs[i].v});
      checkOutput($sformatf("vec%0d busy", i),  {16'd0, fix_busy},  {16'd0, vecs[i].b});
    end

    // Round-robin fairness with all requesters active.
    $display("[TB] round-robin sequence");
    applyStimulus(1, 1, 4'b0000, 0);
    checkOutput("rr reset valid", {31'd0, rr_valid}, 32'd0);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(0, 1, 4'b1111, 0);
      checkOutput($sformatf("rr turn%0d idx", k),   {30'd0, rr_idx},   32'(k % 4));
      checkOutput($sformatf("rr turn%0d grant", k), {28'd0, rr_grant}, 32'd1 << (k % 4));
      applyStimulus(0, 1, 4'b1111, 1);
      checkOutput($sformatf("rr turn%0d release gap", k), {28'd0, rr_grant}, 32'd0);
      applyStimulus(0, 1, 4'b1111, 0);
      checkOutput($sformatf("rr turn%0d idle gap", k), {28'd0, rr_grant}, 32'd0);
    end

    // Reset mid-grant must clear outputs and the pointer with no release cycle.
    applyStimulus(0, 1, 4'b0100, 0);
    checkOutput("rr pre-reset grant", {28'd0, rr_grant}, 32'h4);
    applyStimulus(1, 1, 4'b0100, 0);
    checkOutput("rr mid reset grant", {28'd0, rr_grant}, 32'd0);
    checkOutput("rr mid reset idx",   {30'd0, rr_idx},   32'd0);
    checkOutput("rr mid reset valid", {31'd0, rr_valid}, 32'd0);
    checkOutput("rr mid reset busy",  {16'd0, rr_busy},  32'd0);
    applyStimulus(0, 1, 4'b1111, 0);
    checkOutput("rr post-reset idx",   {30'd0, rr_idx},   32'd0);
    checkOutput("rr post-reset grant", {28'd0, rr_grant}, 32'h1);

    // N = 8: counter accumulation, saturation, and pointer wrap.
    $display("[TB] N=8 counter and wrap");
    req8 = 8'h00;
    applyStimulus(1, 1, 4'b0000, 0);
    checkOutput("w8 reset busy", {16'd0, w8_busy}, 32'd0);
    req8 = 8'h20;
    applyStimulus(0, 1, 4'b0000, 0);
    checkOutput("w8 first grant", {24'd0, w8_grant}, 32'h20);
    checkOutput("w8 first idx",   {29'd0, w8_idx},   32'd5);
    checkOutput("w8 first busy",  {16'd0, w8_busy},  32'd0);
    repeat (20) applyStimulus(0, 1, 4'b0000, 0);
    checkOutput("w8 busy after 20", {16'd0, w8_busy}, 32'd20);
    checkOutput("w8 held grant",    {24'd0, w8_grant}, 32'h20);
    repeat (65535 - 20) applyStimulus(0, 1, 4'b0000, 0);
    checkOutput("w8 busy at max", {16'd0, w8_busy}, 32'hFFFF);
    repeat (3) applyStimulus(0, 1, 4'b0000, 0);
    checkOutput("w8 busy saturated", {16'd0, w8_busy}, 32'hFFFF);
    checkOutput("w8 still valid",    {31'd0, w8_valid}, 32'd1);

    req8 = 8'h00;
    applyStimulus(0, 1, 4'b0000, 0);
    checkOutput("w8 drop release", {24'd0, w8_grant}, 32'd0);
    applyStimulus(0, 1, 4'b0000, 0);
    req8 = 8'h81;
    applyStimulus(0, 1, 4'b0000, 0);
    checkOutput("w8 ptr6 picks 7", {29'd0, w8_idx}, 32'd7);
    req8 = 8'h00;
    applyStimulus(0, 1, 4'b0000, 0);
    applyStimulus(0, 1, 4'b0000, 0);
    req8 = 8'h81;
    applyStimulus(0, 1, 4'b0000, 0);
    checkOutput("w8 wrap picks 0",  {29'd0, w8_idx},   32'd0);
    checkOutput("w8 wrap grant",    {24'd0, w8_grant}, 32'h01);
    checkOutput("w8 busy held max", {16'd0, w8_busy},  32'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
